// File: rtl/vga_pkg.sv
// Shared VGA-path definitions: screen geometry defaults, colour constants
// and the rectangle fill FSM state encoding.
package vga_pkg;

   localparam int SCREEN_W_DEF = 160;
   localparam int SCREEN_H_DEF = 120;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } fill_state_e;

endpackage

// File: rtl/rect_fill_engine_if.sv
// Request/pixel-stream bundle between the game FSM (master) and the
// rectangle fill engine (slave).
interface rect_fill_engine_if #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3
);
   logic                go;
   logic [X_W-1:0]      in_x;
   logic [Y_W-1:0]      in_y;
   logic [X_W-1:0]      in_w;
   logic [Y_W-1:0]      in_h;
   logic [COLOUR_W-1:0] in_colour;
   logic [X_W-1:0]      out_x;
   logic [Y_W-1:0]      out_y;
   logic [COLOUR_W-1:0] out_colour;
   logic                plot;
   logic                busy;
   logic                done;

   modport master (
      output go, in_x, in_y, in_w, in_h, in_colour,
      input  out_x, out_y, out_colour, plot, busy, done
   );

   modport slave (
      input  go, in_x, in_y, in_w, in_h, in_colour,
      output out_x, out_y, out_colour, plot, busy, done
   );
endinterface

// File: rtl/rect_scan_counter.sv
// Raster-order (x fastest) cx/cy counter bounded by the latched width and
// height; flags the final pixel of the rectangle.
module rect_scan_counter #(
   parameter int X_W = 8,
   parameter int Y_W = 7
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           clear_i,
   input  logic           en_i,
   input  logic [X_W-1:0] w_i,
   input  logic [Y_W-1:0] h_i,
   output logic [X_W-1:0] cx_o,
   output logic [Y_W-1:0] cy_o,
   output logic           last_o
);
   localparam logic [X_W-1:0] X_ONE = X_W'(1);
   localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

   logic [X_W-1:0] cx_q, cx_d;
   logic [Y_W-1:0] cy_q, cy_d;
   logic           row_end_s;

   // w and h are never zero while enabled, so the -1 cannot wrap in use
   assign row_end_s = (cx_q == (w_i - X_ONE));
   assign last_o    = row_end_s && (cy_q == (h_i - Y_ONE));
   assign cx_o      = cx_q;
   assign cy_o      = cy_q;

   // next-state for the raster counter
   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (clear_i) begin
         cx_d = '0;
         cy_d = '0;
      end else if (en_i) begin
         if (row_end_s) begin
            cx_d = '0;
            cy_d = cy_q + Y_ONE;
         end else begin
            cx_d = cx_q + X_ONE;
            cy_d = cy_q;
         end
      end else begin
         cx_d = cx_q;
         cy_d = cy_q;
      end
   end

   // counter registers
   always_ff @(posedge clock) begin
      if (!resetn) begin
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end
endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: latches a request on go, streams one clipped pixel
// per clock in raster order, then pulses done.
module rect_fill_engine
   import vga_pkg::*;
#(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3,
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF
) (
   input logic              clock,
   input logic              resetn,
   rect_fill_engine_if.slave bus
);
   localparam logic [X_W:0] SCREEN_W_L = SCREEN_W[X_W:0];
   localparam logic [Y_W:0] SCREEN_H_L = SCREEN_H[Y_W:0];

   fill_state_e         state_q, state_d;
   logic [X_W-1:0]      x0_q, x0_d, w_q, w_d;
   logic [Y_W-1:0]      y0_q, y0_d, h_q, h_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;
   logic                accept_s, cnt_en_s, last_s;
   logic [X_W-1:0]      cx_s;
   logic [Y_W-1:0]      cy_s;
   logic [X_W:0]        sum_x_s;
   logic [Y_W:0]        sum_y_s;

   rect_scan_counter #(
      .X_W (X_W),
      .Y_W (Y_W)
   ) u_scan (
      .clock   (clock),
      .resetn  (resetn),
      .clear_i (accept_s),
      .en_i    (cnt_en_s),
      .w_i     (w_q),
      .h_i     (h_q),
      .cx_o    (cx_s),
      .cy_o    (cy_s),
      .last_o  (last_s)
   );

   // FSM next state; go is only looked at in IDLE
   always_comb begin
      state_d  = state_q;
      accept_s = 1'b0;
      cnt_en_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.go) begin
               accept_s = 1'b1;
               if ((bus.in_w == '0) || (bus.in_h == '0)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DRAW;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAW: begin
            cnt_en_s = 1'b1;
            if (last_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAW;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // request latch next values
   always_comb begin
      x0_d     = x0_q;
      y0_d     = y0_q;
      w_d      = w_q;
      h_d      = h_q;
      colour_d = colour_q;
      if (accept_s) begin
         x0_d     = bus.in_x;
         y0_d     = bus.in_y;
         w_d      = bus.in_w;
         h_d      = bus.in_h;
         colour_d = bus.in_colour;
      end else begin
         x0_d     = x0_q;
         y0_d     = y0_q;
         w_d      = w_q;
         h_d      = h_q;
         colour_d = colour_q;
      end
   end

   // state and latched request registers
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         x0_q     <= '0;
         y0_q     <= '0;
         w_q      <= '0;
         h_q      <= '0;
         colour_q <= '0;
      end else begin
         state_q  <= state_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         w_q      <= w_d;
         h_q      <= h_d;
         colour_q <= colour_d;
      end
   end

   // one extra bit so the clip test sees coordinates past the wrap point
   assign sum_x_s = {1'b0, x0_q} + {1'b0, cx_s};
   assign sum_y_s = {1'b0, y0_q} + {1'b0, cy_s};

   assign bus.out_x      = sum_x_s[X_W-1:0];
   assign bus.out_y      = sum_y_s[Y_W-1:0];
   assign bus.out_colour = colour_q;
   assign bus.plot       = (state_q == ST_DRAW) && (sum_x_s < SCREEN_W_L) && (sum_y_s < SCREEN_H_L);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = (state_q == ST_DONE);
endmodule
